fp_to_int: RTL and testbench



---
 rtl/fp_pkg.sv | 17 +
 rtl/fp_to_int_shift_calc.sv | 27 ++
 rtl/fp_to_int.sv | 170 +++++++++++++++++
 tb/tb_fp_to_int.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared float-format constants and control-state encoding for the float datapath blocks.
package fp_pkg;

    localparam int FP_M_W        = 16;
    localparam int FP_E_W        = 8;
    localparam int FP_M_FRAC     = 15;
    // Beyond 17 right shifts every mantissa has already collapsed to 0 after rounding.
    localparam int FP_RSHIFT_CAP = 17;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ROUND,
        DONE
    } fp_state_t;

endpackage

// File: rtl/fp_to_int_shift_calc.sv
// Derives shift direction and capped shift count from the float exponent.
import fp_pkg::*;

module fp_to_int_shift_calc #(
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 0,
    parameter int CNT_W     = 6
) (
    input  logic [FP_E_W-1:0] e,
    output logic              dir,
    output logic [CNT_W-1:0]  cnt
);

    logic [9:0] k;
    logic [9:0] mag;
    logic [9:0] cap;

    always_comb begin
        // k = e - 15 + FRAC_BITS in 10-bit two's complement; dir=1 means right shift.
        k   = {{2{e[FP_E_W-1]}}, e} - 10'(FP_M_FRAC) + 10'(FRAC_BITS);
        dir = k[9];
        mag = dir ? (~k + 10'd1) : k;
        cap = dir ? 10'(FP_RSHIFT_CAP) : 10'(OUT_W);
        cnt = (mag > cap) ? cap[CNT_W-1:0] : mag[CNT_W-1:0];
    end

endmodule

// File: rtl/fp_to_int.sv
// Iterative float {m,e} to saturated signed fixed-point converter, one shift per clock.
// Build option FP_TO_INT_TRUNC_EN: truncate (toward -inf) instead of round-half-up.
import fp_pkg::*;

module fp_to_int #(
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FP_M_W+FP_E_W-1:0]      in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_sat,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int CNT_W = $clog2(OUT_W + 1);

    localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_NEG = {1'b1, {(OUT_W-1){1'b0}}};

    fp_state_t state;
    fp_state_t state_next;

    logic [OUT_W-1:0] acc;
    logic             guard;
    logic             sat;
    logic [CNT_W-1:0] cnt;
    logic             dir;
    logic             m_neg;
    logic             m_zero;

    logic [FP_M_W-1:0] in_m;
    logic [FP_E_W-1:0] in_e;
    logic              calc_dir;
    logic [CNT_W-1:0]  calc_cnt;

    logic              round_guard;
    logic [OUT_W-1:0]  round_data;
    logic              round_sat;

    assign in_m = in_data[FP_M_W+FP_E_W-1:FP_E_W];
    assign in_e = in_data[FP_E_W-1:0];

    fp_to_int_shift_calc #(
        .OUT_W     (OUT_W),
        .FRAC_BITS (FRAC_BITS),
        .CNT_W     (CNT_W)
    ) u_shift_calc (
        .e   (in_e),
        .dir (calc_dir),
        .cnt (calc_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef FP_TO_INT_TRUNC_EN
    assign round_guard = 1'b0;
`else
    assign round_guard = guard;
`endif

    always_comb begin
        round_data = '0;
        round_sat  = 1'b0;
        if (m_zero) begin
            round_data = '0;
            round_sat  = 1'b0;
        end else if (sat) begin
            round_data = m_neg ? MIN_NEG : MAX_POS;
            round_sat  = 1'b1;
        end else if (round_guard && (acc == MAX_POS)) begin
            round_data = MAX_POS;
            round_sat  = 1'b1;
        end else begin
            round_data = acc + OUT_W'(round_guard);
            round_sat  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            guard    <= 1'b0;
            sat      <= 1'b0;
            cnt      <= '0;
            dir      <= 1'b0;
            m_neg    <= 1'b0;
            m_zero   <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= OUT_W'(signed'(in_m));
                        guard  <= 1'b0;
                        sat    <= 1'b0;
                        cnt    <= calc_cnt;
                        dir    <= calc_dir;
                        m_neg  <= in_m[FP_M_W-1];
                        m_zero <= (in_m == '0);
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        if (dir) begin
                            acc   <= {acc[OUT_W-1], acc[OUT_W-1:1]};
                            guard <= acc[0];
                        end else begin
                            // A sign change about to happen means the value no longer fits.
                            if (acc[OUT_W-1] != acc[OUT_W-2]) begin
                                sat <= 1'b1;
                            end
                            acc <= {acc[OUT_W-2:0], 1'b0};
                        end
                    end
                end
                ROUND: begin
                    out_data <= round_data;
                    out_sat  <= round_sat;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// Directed-vector bench for fp_to_int (OUT_W=16, FRAC_BITS=0); honours FP_TO_INT_TRUNC_EN.
module tb_fp_to_int;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] m;
        logic [7:0]  e;
        int          lat;
        logic [15:0] d;
        logic        s;
    } vec_t;

    vec_t vecs[10];

    fp_to_int #(
        .OUT_W     (16),
        .FRAC_BITS (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Latency counts the accept edge itself, so a zero-shift operand reports 3.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic send(input logic [15:0] m, input logic [7:0] e);
        @(negedge clk);
        in_data  = {m, e};
        in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic convert(input vec_t v, input int idx);
        int lat;
        send(v.m, v.e);
        wait_valid(lat);
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_data", idx), 32'(out_data), 32'(v.d));
        check($sformatf("v%0d_sat", idx), 32'(out_sat), 32'(v.s));
        @(posedge clk);
        #1;
        check($sformatf("v%0d_valid_drop", idx), 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int stray;

        vecs[0] = '{16'h4000, 8'd5,   13, 16'd16,   1'b0};
        vecs[1] = '{16'hC000, 8'd15,  3,  16'hC000, 1'b0};
        vecs[2] = '{16'h0000, 8'd40,  19, 16'h0000, 1'b0};
        vecs[3] = '{16'h4000, 8'd20,  8,  16'h7FFF, 1'b1};
        vecs[4] = '{16'hC000, 8'd20,  8,  16'h8000, 1'b1};
        vecs[5] = '{16'h4000, 8'hF0,  20, 16'h0000, 1'b0};
`ifdef FP_TO_INT_TRUNC_EN
        vecs[6] = '{16'h0003, 8'd14,  4,  16'h0001, 1'b0};
        vecs[7] = '{16'hFFFD, 8'd14,  4,  16'hFFFE, 1'b0};
`else
        vecs[6] = '{16'h0003, 8'd14,  4,  16'h0002, 1'b0};
        vecs[7] = '{16'hFFFD, 8'd14,  4,  16'hFFFF, 1'b0};
`endif
        vecs[8] = '{16'h8000, 8'd16,  4,  16'h8000, 1'b1};
        vecs[9] = '{16'h8000, 8'd0,   18, 16'hFFFF, 1'b0};

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_sat", 32'(out_sat), 32'd0);

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i], i);
        end

        // Backpressure: hold DONE for 5 clocks while a second operand waits.
        out_ready = 1'b0;
        send(16'h4000, 8'd5);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd13);
        in_data  = {16'hC000, 8'd15};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_data", i), 32'(out_data), 32'd16);
            check($sformatf("bp_hold%0d_sat", i), 32'(out_sat), 32'd0);
            check($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_handshake_valid_drop", 32'(out_valid), 32'd0);
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("bp_second_latency", 32'(lat), 32'd3);
        check("bp_second_data", 32'(out_data), 32'hC000);
        check("bp_second_sat", 32'(out_sat), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a k=-10 shift sequence discards the operand.
        send(16'h4000, 8'd5);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_sat", 32'(out_sat), 32'd0);
        stray = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        check("midrst_no_output", 32'(stray), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
